icache_refill_ctrl: RTL and testbench

Miss-handling sequencer for the direct-mapped instruction cache: it detects a fetch miss, holds the fetch stage, issues a block-aligned refill request to instruction memory, and counts the fixed memory latency. It then produces the one-cycle `countdone` strobe that commits the cache's valid bit and tag, and releases the stall once the cache reports a hit. It sits between the IF stage (pc, stall), the instruction cache (hit_miss, countdone) and the memory port.

---
 rtl/icache_refill_ctrl.sv | 120 ++++++++++++
 tb/tb_icache_refill_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: I-cache miss sequencer. Stalls IF, issues a block refill and strobes countdone to commit tag/valid.
// Latency: a miss sampled in cycle 0 gives FILL in cycles 1..MEM_LATENCY and countdone in cycle MEM_LATENCY, then RESUME until a hit.
// Backpressure: stall is asserted combinationally in the miss cycle and held in FILL/RESUME. ICACHE_PERF_EN enables miss/stall counters.
module icache_refill_ctrl #(
    parameter int MEM_LATENCY = 4,
    parameter int CNT_WIDTH   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        fetch_valid,
    input  logic        hit_miss,
    input  logic        flush,
    output logic        stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic        countdone,
    output logic        refill_busy,
    output logic [31:0] miss_cnt,
    output logic [31:0] stall_cnt
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FILL   = 2'd1;
    localparam logic [1:0] ST_RESUME = 2'd2;

    localparam logic [CNT_WIDTH-1:0] LP_CNT_LOAD = CNT_WIDTH'(MEM_LATENCY - 1);

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [31:0]          r_mem_addr;
    logic                 r_abort;

    logic w_start;
    logic w_done;

    // A new refill starts only from IDLE on a wanted fetch that missed.
    assign w_start = (r_state == ST_IDLE) && fetch_valid && !hit_miss && !flush;
    // Last FILL cycle: memory data is in, the cache commits at this edge.
    assign w_done  = (r_state == ST_FILL) && (r_cnt == '0);

    assign stall       = (r_state != ST_IDLE) || w_start;
    assign mem_req     = (r_state == ST_FILL);
    assign countdone   = w_done;
    assign refill_busy = (r_state != ST_IDLE);
    assign mem_addr    = r_mem_addr;

    // Next-state selection; a flush seen at any point of FILL skips RESUME.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = ST_FILL;
                end
            end
            ST_FILL: begin
                if (w_done) begin
                    w_state_nxt = (r_abort || flush) ? ST_IDLE : ST_RESUME;
                end
            end
            ST_RESUME: begin
                if (hit_miss || flush) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, latency counter, refill address and sticky abort flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_mem_addr <= '0;
            r_abort    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_cnt      <= LP_CNT_LOAD;
                r_mem_addr <= pc & 32'hFFFF_FFF8;
                r_abort    <= 1'b0;
            end else if (r_state == ST_FILL) begin
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - 1'b1;
                end
                r_abort <= w_done ? 1'b0 : (r_abort || flush);
            end
        end
    end

`ifdef ICACHE_PERF_EN
    logic [31:0] r_miss_cnt;
    logic [31:0] r_stall_cnt;

    // Saturating performance counters for refills started and stalled cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_miss_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_start && (r_miss_cnt != 32'hFFFF_FFFF)) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
            if (stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign miss_cnt  = r_miss_cnt;
    assign stall_cnt = r_stall_cnt;
`else
    assign miss_cnt  = 32'd0;
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
module tb_icache_refill_ctrl;

    typedef struct {
        logic [31:0] addr;
        int          len;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        fetch_valid;
    logic        hit_miss;
    logic        flush;
    logic        sel;
    logic        fv4;
    logic        fv1;

    logic        stall4, req4, cd4, busy4;
    logic [31:0] addr4, mcnt4, scnt4;
    logic        stall1, req1, cd1, busy1;
    logic [31:0] addr1, mcnt1, scnt1;

    int n_cmp = 0;
    int n_err = 0;
    exp_t q4[$];
    exp_t q1[$];
    int run4 = 0;
    int run1 = 0;
    logic prev4 = 1'b0;
    logic prev1 = 1'b0;

    assign fv4 = fetch_valid & ~sel;
    assign fv1 = fetch_valid & sel;

    icache_refill_ctrl #(.MEM_LATENCY(4), .CNT_WIDTH(8)) u_dut4 (
        .clk(clk), .rst(rst), .pc(pc), .fetch_valid(fv4), .hit_miss(hit_miss),
        .flush(flush), .stall(stall4), .mem_req(req4), .mem_addr(addr4),
        .countdone(cd4), .refill_busy(busy4), .miss_cnt(mcnt4), .stall_cnt(scnt4)
    );

    icache_refill_ctrl #(.MEM_LATENCY(1), .CNT_WIDTH(8)) u_dut1 (
        .clk(clk), .rst(rst), .pc(pc), .fetch_valid(fv1), .hit_miss(hit_miss),
        .flush(flush), .stall(stall1), .mem_req(req1), .mem_addr(addr1),
        .countdone(cd1), .refill_busy(busy1), .miss_cnt(mcnt1), .stall_cnt(scnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard monitor for the latency-4 instance.
    always @(negedge clk) begin
        if (rst) begin
            run4  = 0;
            prev4 = 1'b0;
        end else begin
            if (req4) run4++;
            if (cd4) begin
                check("cd4_in_fill", {31'd0, req4}, 32'd1);
                check("cd4_width", {31'd0, prev4}, 32'd0);
                if (q4.size() == 0) begin
                    check("cd4_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q4.pop_front();
                    check("cd4_mem_addr", addr4, e.addr);
                    check("cd4_fill_len", run4, e.len);
                end
            end
            if (!req4) run4 = 0;
            prev4 = cd4;
        end
    end

    // Scoreboard monitor for the latency-1 instance.
    always @(negedge clk) begin
        if (rst) begin
            run1  = 0;
            prev1 = 1'b0;
        end else begin
            if (req1) run1++;
            if (cd1) begin
                check("cd1_in_fill", {31'd0, req1}, 32'd1);
                check("cd1_width", {31'd0, prev1}, 32'd0);
                if (q1.size() == 0) begin
                    check("cd1_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q1.pop_front();
                    check("cd1_mem_addr", addr1, e.addr);
                    check("cd1_fill_len", run1, e.len);
                end
            end
            if (!req1) run1 = 0;
            prev1 = cd1;
        end
    end

    // One miss on the selected instance; flush_at>0 asserts flush in that cycle (cycle 0 = miss).
    task automatic run_miss(input logic s, input logic [31:0] a, input int flush_at,
                            input int exp_stall, input int exp_req, input int lat);
        exp_t e;
        int c = 0;
        int stall_n = 0;
        int req_n = 0;
        bit done = 0;
        bit cd_seen = 0;
        logic s_stall, s_req, s_cd, s_busy;
        logic [31:0] s_addr;
        e.addr = a & 32'hFFFF_FFF8;
        e.len  = lat;
        if (s) q1.push_back(e); else q4.push_back(e);
        sel = s; pc = a; fetch_valid = 1'b1; hit_miss = 1'b0; flush = 1'b0;
        while (!done && c < 40) begin
            @(negedge clk);
            s_stall = s ? stall1 : stall4;
            s_req   = s ? req1   : req4;
            s_cd    = s ? cd1    : cd4;
            if (c == 0) check("stall_same_cycle", {31'd0, s_stall}, 32'd1);
            if (c > 0 && !s_stall) begin
                done = 1;
            end else begin
                stall_n += int'(s_stall);
                req_n   += int'(s_req);
                if (s_cd) cd_seen = 1;
                @(posedge clk); #1;
                c++;
                flush = (flush_at != 0 && c == flush_at);
                if (cd_seen) begin
                    if (flush_at != 0) fetch_valid = 1'b0;
                    else hit_miss = 1'b1;
                end
            end
        end
        s_busy = s ? busy1 : busy4;
        s_addr = s ? addr1 : addr4;
        check("miss_completes", {31'd0, done}, 32'd1);
        check("stall_cycles", stall_n, exp_stall);
        check("mem_req_cycles", req_n, exp_req);
        check("busy_after", {31'd0, s_busy}, 32'd0);
        check("mem_addr_hold", s_addr, e.addr);
    endtask

    task automatic do_reset();
        rst = 1'b1; sel = 1'b0; pc = '0; fetch_valid = 1'b0; hit_miss = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int bad;
        do_reset();
        @(negedge clk);
        check("rst_stall", {31'd0, stall4}, 32'd0);
        check("rst_mem_req", {31'd0, req4}, 32'd0);
        check("rst_countdone", {31'd0, cd4}, 32'd0);
        check("rst_busy", {31'd0, busy4}, 32'd0);
        check("rst_mem_addr", addr4, 32'd0);
        check("rst_miss_cnt", mcnt4, 32'd0);
        check("rst_stall_cnt", scnt4, 32'd0);

        // Hits only: nothing should move.
        @(posedge clk); #1;
        fetch_valid = 1'b1; hit_miss = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bad += int'(stall4) + int'(req4) + int'(cd4);
        end
        check("hits_no_activity", bad, 0);

        // Plain miss: 4 FILL cycles, 6 stall cycles.
        @(posedge clk); #1;
        run_miss(1'b0, 32'h0000_2014, 0, 6, 4, 4);

        // Flush in the 2nd FILL cycle: countdone still pulses, RESUME skipped.
        @(posedge clk); #1;
        run_miss(1'b0, 32'h0000_3000, 2, 5, 4, 4);

        // Reset in the 3rd FILL cycle: outputs drop at once, no countdone.
        @(posedge clk); #1;
        sel = 1'b0; pc = 32'h0000_0040; fetch_valid = 1'b1; hit_miss = 1'b0; flush = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        #1 rst = 1'b1; fetch_valid = 1'b0;
        #1;
        check("async_rst_stall", {31'd0, stall4}, 32'd0);
        check("async_rst_mem_req", {31'd0, req4}, 32'd0);
        check("async_rst_busy", {31'd0, busy4}, 32'd0);
        check("async_rst_mem_addr", addr4, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        run_miss(1'b0, 32'h0000_0044, 0, 6, 4, 4);

        // Counter phase: fresh reset, three misses, then the latency-1 pair.
        do_reset();
        @(negedge clk);
        check("perf_rst_miss_cnt", mcnt4, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            run_miss(1'b0, 32'h0000_1000 + 32'(i * 8), 0, 6, 4, 4);
        end
        @(posedge clk); #1;
        run_miss(1'b1, 32'h0000_0000, 0, 3, 1, 1);
        @(posedge clk); #1;
        run_miss(1'b1, 32'h0000_0008, 0, 3, 1, 1);
        @(posedge clk); #1;
        sel = 1'b0; fetch_valid = 1'b0;
        @(negedge clk);
`ifdef ICACHE_PERF_EN
        check("miss_cnt4", mcnt4, 32'd3);
        check("stall_cnt4", scnt4, 32'd18);
        check("miss_cnt1", mcnt1, 32'd2);
        check("stall_cnt1", scnt1, 32'd6);
`else
        check("miss_cnt4", mcnt4, 32'd0);
        check("stall_cnt4", scnt4, 32'd0);
        check("miss_cnt1", mcnt1, 32'd0);
        check("stall_cnt1", scnt1, 32'd0);
`endif
        check("q4_drained", q4.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
